mealy_fsm_monitor: RTL

Synthesizable trace checker for the two-bit, four-state Mealy FSM. It sits on the FSM's observation interface (input, output, current state, next state) and checks every clock against a programmed transition table and against state continuity. It keeps sticky first-error capture and saturating counters for bring-up and BIST readout. It is the hardware counterpart of the FSM's directed bench, usable in-system.

---
 rtl/mealy_fsm_monitor.sv | 100 ++++++++++
 1 files changed

// File: rtl/mealy_fsm_monitor.sv
// mealy_fsm_monitor: in-system trace checker for a 2-bit, four-state Mealy FSM
//
// Checks every enabled sample of (i_current_state, i_input, i_output, i_next_state)
// against a programmed transition table and against state continuity. It keeps a
// sticky first-error capture and saturating sample/error counters.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_en                sample the trace this cycle
//   i_clear             synchronous clear, same effect as rst
//   i_input, i_output   FSM input i(k) and output o(k)
//   i_current_state     s(k)
//   i_next_state        s(k+1) as announced by the FSM
//   o_err, o_err_code   sticky error flag and first-error cause bits
//                       {wrong initial, continuity, next mismatch, output mismatch}
//   o_err_cycle         sample index of the first error
//   o_err_state/input   s(k) and i(k) of the first error
//   o_check_cnt         samples checked (saturating)
//   o_err_cnt           samples with any error (saturating)
//   o_busy              monitor is in ARMED or CHECKING
module mealy_fsm_monitor #(
    parameter logic [23:0] TABLE       = 24'h85DC1E,
    parameter logic [1:0]  RESET_STATE = 2'b00,
    parameter int          CNT_W       = 16,
    parameter bit          STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clear,
    input  logic             i_input,
    input  logic             i_output,
    input  logic [1:0]       i_current_state,
    input  logic [1:0]       i_next_state,
    output logic             o_err,
    output logic [3:0]       o_err_code,
    output logic [CNT_W-1:0] o_err_cycle,
    output logic [1:0]       o_err_state,
    output logic             o_err_input,
    output logic [CNT_W-1:0] o_check_cnt,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic             o_busy
);
    typedef enum logic [2:0] {IDLE, FIRST, ARMED, CHECKING, HALTED} state_t;
    state_t state, state_nxt;
    logic [1:0] prev_ns;
    logic [4:0] lo;
    logic [2:0] entry;
    logic [3:0] cause;
    logic       sample;

    // Each table entry is 3 bits wide, so entry idx starts at bit 3*idx.
    assign lo    = {2'b00, i_current_state, i_input} * 5'd3;
    assign entry = TABLE[lo +: 3];

    always_comb begin
        sample    = i_en && (state == FIRST || state == ARMED || state == CHECKING);
        cause     = {state == FIRST && i_current_state != RESET_STATE,
                     state == CHECKING && i_current_state != prev_ns,
                     i_next_state != entry[1:0],
                     i_output != entry[2]};
        state_nxt = state == IDLE                                ? FIRST    :
                    (state == FIRST || state == ARMED) && i_en   ? CHECKING :
                    state == CHECKING && !i_en                   ? ARMED    : state;
        if (STOP_ON_ERR && sample && |cause)
            state_nxt = HALTED;
    end

    assign o_busy = state == ARMED || state == CHECKING;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            state       <= IDLE;
            prev_ns     <= '0;
            o_err       <= 1'b0;
            o_err_code  <= '0;
            o_err_cycle <= '0;
            o_err_state <= '0;
            o_err_input <= 1'b0;
            o_check_cnt <= '0;
            o_err_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (sample) begin
                prev_ns     <= i_next_state;
                o_check_cnt <= o_check_cnt + CNT_W'(o_check_cnt != '1);
                if (|cause) begin
                    o_err_cnt <= o_err_cnt + CNT_W'(o_err_cnt != '1);
                    if (!o_err) begin
                        o_err       <= 1'b1;
                        o_err_code  <= cause;
                        o_err_cycle <= o_check_cnt;
                        o_err_state <= i_current_state;
                        o_err_input <= i_input;
                    end
                end
            end
        end
    end
endmodule
